// File: rtl/dmem_run_ctrl.sv
// dmem_run_ctrl: run sequencer and data-memory arbiter for the 8-bit core.
// The host owns memory while the core is held in reset. A run request hands
// memory to the core. The run ends when the program counter reaches DONE_PC
// or the watchdog expires, and memory then returns to the host for readback.
module dmem_run_ctrl #(
    parameter int D       = 12,
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int DONE_PC = 128,
    parameter int MAX_CYC = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [D-1:0]  prog_ctr,
    input  logic          core_wr_en,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdat,
    output logic [DW-1:0] core_rdat,
    input  logic          host_wr_en,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdat,
    output logic [DW-1:0] host_rdat,
    output logic          host_gnt,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdat,
    input  logic [DW-1:0] mem_rdat,
    output logic          core_reset,
    output logic          done,
    output logic          busy,
    output logic          timeout,
    output logic [15:0]   cycle_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [D-1:0] DONE_PC_V  = D'(DONE_PC);
    localparam logic [15:0]  WDOG_LAST  = 16'(MAX_CYC - 1);

    state_t      state;
    state_t      state_nxt;
    logic        timeout_nxt;
    logic [15:0] cycle_cnt_nxt;
    logic        core_reset_nxt;
    logic        done_nxt;
    logic        busy_nxt;

    // State and registered status outputs; async reset parks the block in IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            core_reset <= 1'b1;
            done       <= 1'b0;
            busy       <= 1'b0;
            timeout    <= 1'b0;
            cycle_cnt  <= 16'h0000;
        end else begin
            state      <= state_nxt;
            core_reset <= core_reset_nxt;
            done       <= done_nxt;
            busy       <= busy_nxt;
            timeout    <= timeout_nxt;
            cycle_cnt  <= cycle_cnt_nxt;
        end
    end

    // Next-state logic; abort beats PC completion, which in turn beats the watchdog
    always_comb begin
        state_nxt     = state;
        timeout_nxt   = timeout;
        cycle_cnt_nxt = cycle_cnt;
        unique case (state)
            ST_IDLE: begin
                if (req) begin
                    state_nxt     = ST_START;
                    cycle_cnt_nxt = 16'h0000;
                    timeout_nxt   = 1'b0;
                end
            end
            ST_START: begin
                state_nxt = req ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                if (cycle_cnt != 16'hFFFF) begin
                    cycle_cnt_nxt = cycle_cnt + 16'd1;
                end
                if (!req) begin
                    state_nxt = ST_IDLE;
                end else if (prog_ctr == DONE_PC_V) begin
                    state_nxt   = ST_DONE;
                    timeout_nxt = 1'b0;
                end else if (cycle_cnt == WDOG_LAST) begin
                    state_nxt   = ST_DONE;
                    timeout_nxt = 1'b1;
                end
            end
            ST_DONE: begin
                if (!req) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        core_reset_nxt = (state_nxt != ST_RUN);
        done_nxt       = (state_nxt == ST_DONE);
        busy_nxt       = (state_nxt == ST_START) || (state_nxt == ST_RUN);
    end

    // Memory port mux; the core owns memory only in RUN, and the host only in IDLE/DONE
    always_comb begin
        host_gnt = (state == ST_IDLE) || (state == ST_DONE);
        if (state == ST_RUN) begin
            mem_addr  = core_addr;
            mem_wdat  = core_wdat;
            mem_wr_en = core_wr_en;
        end else begin
            mem_addr  = host_addr;
            mem_wdat  = host_wdat;
            mem_wr_en = host_wr_en & host_gnt;
        end
        core_rdat = mem_rdat;
        host_rdat = mem_rdat;
    end

endmodule
